// File: rtl/async_up_down_counter.sv
// async_up_down_counter: free-running WIDTH-bit up/down counter.
// Fully synchronous to clk with a synchronous active-high reset; the
// historical "async" in the name refers to nothing in this design.
// mode = 0 counts up, mode = 1 counts down. tc is a combinational
// terminal-count flag, asserted while the next edge would wrap.
// Optional build macro ASYNC_UP_DOWN_COUNTER_SAT_EN: saturate at the
// direction's limit instead of wrapping; tc then flags the held limit.
module async_up_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_limit;

    // Limit for the currently selected direction: all-ones going up, zero going down.
    always_comb begin
        at_limit = 1'b0;
        if (mode) begin
            at_limit = (count_q == CNT_ZERO);
        end else begin
            at_limit = (count_q == CNT_ONES);
        end
    end

    // Next count: reset wins, otherwise step one in the sampled direction.
    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = CNT_ZERO;
`ifdef ASYNC_UP_DOWN_COUNTER_SAT_EN
        end else if (at_limit) begin
            count_d = count_q;
`endif
        end else if (mode) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Single state register; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
    // Same-cycle wrap (or saturation) indicator, suppressed during reset.
    assign tc    = ~rst & at_limit;

endmodule

// File: tb/tb_async_up_down_counter.sv
// Self-checking bench for async_up_down_counter (WIDTH = 4, 10 ns clock).
// Directed scenarios followed by random rst/mode traffic, all checked
// against an arithmetic reference model. Honours ASYNC_UP_DOWN_COUNTER_SAT_EN.
module tb_async_up_down_counter;

    localparam int unsigned WIDTH = 4;
    localparam int          MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tc;

    int n_checks;
    int n_fail;
    int model_count;
    bit model_known;

    async_up_down_counter #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .count(count),
        .tc   (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int c, input bit r, input bit m);
        if (r) return 0;
`ifdef ASYNC_UP_DOWN_COUNTER_SAT_EN
        if (m) return (c == 0) ? 0 : c - 1;
        return (c == MODV - 1) ? MODV - 1 : c + 1;
`else
        if (m) return (c + MODV - 1) % MODV;
        return (c + 1) % MODV;
`endif
    endfunction

    function automatic bit model_tc(input int c, input bit r, input bit m);
        if (r) return 1'b0;
        return m ? (c == 0) : (c == MODV - 1);
    endfunction

    // Apply inputs between edges, check tc combinationally, clock once, check count.
    task automatic tick(input bit r, input bit m);
        rst  = r;
        mode = m;
        #1;
        if (model_known || r) check("tc_pre", 32'(tc), 32'(model_tc(model_count, r, m)));
        @(posedge clk);
        if (model_known || r) begin
            model_count = model_next(model_count, r, m);
            model_known = 1'b1;
        end
        @(negedge clk);
        check("count", 32'(count), 32'(model_count));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_count = 0;
        model_known = 1'b0;
        rst         = 1'b1;
        mode        = 1'b0;
        @(negedge clk);

        // Reset hold with mode toggling
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'(i));
            check("rst_count", 32'(count), 32'd0);
            check("rst_tc", 32'(tc), 32'd0);
        end

`ifndef ASYNC_UP_DOWN_COUNTER_SAT_EN
        // Up count through the wrap
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        check("up_end", 32'(count), 32'd4);

        // Direction change from 4: 3,2,1,0,15,14
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        check("dir_end", 32'(count), 32'd14);

        // Long down run from 4
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        check("long_start", 32'(count), 32'd4);
        for (int i = 0; i < 180; i++) tick(1'b0, 1'b1);
        check("long_end", 32'(count), 32'd0);

        // Reset mid-count at 9 while counting down
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        check("mid_pre", 32'(count), 32'd9);
        tick(1'b1, 1'b1);
        check("mid_rst", 32'(count), 32'd0);
        tick(1'b0, 1'b0);
        check("mid_after", 32'(count), 32'd1);
`else
        // Saturation: up holds at all-ones, down holds at zero
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        check("sat_up", 32'(count), 32'd15);
        check("sat_up_tc", 32'(tc), 32'd1);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        check("sat_dn", 32'(count), 32'd0);
        check("sat_dn_tc", 32'(tc), 32'd1);
        tick(1'b1, 1'b1);
        check("sat_rst", 32'(count), 32'd0);
`endif

        // Random traffic: direction flips and occasional reset
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        // Down after reset gives all-ones (or holds at zero when saturating)
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
`ifndef ASYNC_UP_DOWN_COUNTER_SAT_EN
        check("rst_then_down", 32'(count), 32'd15);
`else
        check("rst_then_down", 32'(count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
